// File: rtl/spi_command_executor.sv
// spi_command_executor
// Executes sprite commands from the spi_reader byte stream:
//   SAVE_SPRITE : id byte followed by SPRITE_BYTES pixel bytes -> sprite memory writes
//   DRAW_SPRITE : id, x (hi,lo), y (hi,lo), attr -> one entry in the draw request FIFO
// Optional feature: define SPI_EXEC_STATS_EN to add 16-bit counters
// stat_saves / stat_draws / stat_drops.
module spi_command_executor #(
    parameter int         SPRITE_BYTES        = 512,
    parameter int         SPRITE_ID_W         = 8,
    parameter int         DRAW_FIFO_DEPTH     = 4,
    parameter logic [7:0] COMMAND_SAVE_SPRITE = 8'h01,
    parameter logic [7:0] COMMAND_DRAW_SPRITE = 8'h02
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        byte_read,
    input  logic [7:0]                                  data,
    input  logic [7:0]                                  command,
    input  logic [15:0]                                 data_index,
    output logic                                        sprite_we,
    output logic [SPRITE_ID_W+$clog2(SPRITE_BYTES)-1:0] sprite_addr,
    output logic [7:0]                                  sprite_wdata,
    output logic                                        draw_valid,
    input  logic                                        draw_ready,
    output logic [SPRITE_ID_W-1:0]                      draw_sprite_id,
    output logic [15:0]                                 draw_x,
    output logic [15:0]                                 draw_y,
    output logic [7:0]                                  draw_attr,
    output logic                                        draw_overflow
`ifdef SPI_EXEC_STATS_EN
    ,
    output logic [15:0]                                 stat_saves,
    output logic [15:0]                                 stat_draws,
    output logic [15:0]                                 stat_drops
`endif
);

    localparam int              PIX_W   = $clog2(SPRITE_BYTES);
    localparam int              ADDR_W  = SPRITE_ID_W + PIX_W;
    localparam int              PTR_W   = $clog2(DRAW_FIFO_DEPTH);
    localparam logic [15:0]     LAST_K  = 16'(SPRITE_BYTES + 1);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(DRAW_FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE_ID,
        ST_SAVE_PIX,
        ST_DRAW_ARGS
    } state_t;

    typedef struct packed {
        logic [SPRITE_ID_W-1:0] id;
        logic [15:0]            x;
        logic [15:0]            y;
        logic [7:0]             attr;
    } draw_req_t;

    // Stage 1 registers
    logic        byte_v_q, byte_v_d;
    logic [7:0]  byte_q,   byte_d;

    // Stage 2 / FSM registers
    state_t                 state_q,     state_d;
    logic [SPRITE_ID_W-1:0] sprite_id_q, sprite_id_d;
    draw_req_t              shadow_q,    shadow_d;
    logic                   sprite_we_q, sprite_we_d;
    logic [ADDR_W-1:0]      sprite_addr_q, sprite_addr_d;
    logic [7:0]             sprite_wdata_q, sprite_wdata_d;
    logic                   push_q,      push_d;
    draw_req_t              push_req_q,  push_req_d;

    // FIFO control registers
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             overflow_q, overflow_d;

    logic             fifo_full, fifo_pop, push_ok, push_drop;
    logic [PIX_W-1:0] pix_idx;
    draw_req_t        fifo_mem [DRAW_FIFO_DEPTH];
    draw_req_t        head;

    // Pixel index of data byte k is k-2; only the low PIX_W bits matter.
    assign pix_idx = data_index[PIX_W-1:0] - PIX_W'(2);

    // Stage 1: capture the byte strobe together with its byte.
    always_comb begin
        byte_v_d = byte_read;
        byte_d   = data;
    end

    // Stage 2: decode the byte against the now-updated command/data_index.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
        state_d        = state_q;
        sprite_id_d    = sprite_id_q;
        shadow_d       = shadow_q;
        sprite_we_d    = 1'b0;
        sprite_addr_d  = sprite_addr_q;
        sprite_wdata_d = sprite_wdata_q;
        push_d         = 1'b0;
        push_req_d     = push_req_q;

        if (byte_v_q) begin
            if (data_index == 16'd0) begin
                // A command byte restarts decoding from any state; partial work is abandoned.
                if (command == COMMAND_SAVE_SPRITE)      state_d = ST_SAVE_ID;
                else if (command == COMMAND_DRAW_SPRITE) state_d = ST_DRAW_ARGS;
                else                                     state_d = ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_SAVE_ID: begin
                        if (data_index == 16'd1) begin
                            sprite_id_d = byte_q[SPRITE_ID_W-1:0];
                            state_d     = ST_SAVE_PIX;
                        end
                    end
                    ST_SAVE_PIX: begin
                        if (data_index >= 16'd2 && data_index <= LAST_K) begin
                            sprite_we_d    = 1'b1;
                            sprite_addr_d  = {sprite_id_q, pix_idx};
                            sprite_wdata_d = byte_q;
                            if (data_index == LAST_K) state_d = ST_IDLE;
                        end
                    end
                    ST_DRAW_ARGS: begin
                        unique case (data_index)
                            16'd1: shadow_d.id      = byte_q[SPRITE_ID_W-1:0];
                            16'd2: shadow_d.x[15:8] = byte_q;
                            16'd3: shadow_d.x[7:0]  = byte_q;
                            16'd4: shadow_d.y[15:8] = byte_q;
                            16'd5: shadow_d.y[7:0]  = byte_q;
                            16'd6: begin
                                push_d          = 1'b1;
                                push_req_d      = shadow_q;
                                push_req_d.attr = byte_q;
                                state_d         = ST_IDLE;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // FIFO control: a push into a full FIFO survives only if the head pops in the same cycle.
    always_comb begin
        fifo_full  = (count_q == DEPTH_C);
        fifo_pop   = (count_q != '0) && draw_ready;
        push_ok    = push_q && (!fifo_full || fifo_pop);
        push_drop  = push_q && !push_ok;
        wr_ptr_d   = push_ok  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = fifo_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !fifo_pop)      count_d = count_q + (PTR_W+1)'(1);
        else if (!push_ok && fifo_pop) count_d = count_q - (PTR_W+1)'(1);
        overflow_d = overflow_q | push_drop;
    end

    // All control and output registers, synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_v_q       <= 1'b0;
            byte_q         <= '0;
            state_q        <= ST_IDLE;
            sprite_id_q    <= '0;
            shadow_q       <= '0;
            sprite_we_q    <= 1'b0;
            sprite_addr_q  <= '0;
            sprite_wdata_q <= '0;
            push_q         <= 1'b0;
            push_req_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            byte_v_q       <= byte_v_d;
            byte_q         <= byte_d;
            state_q        <= state_d;
            sprite_id_q    <= sprite_id_d;
            shadow_q       <= shadow_d;
            sprite_we_q    <= sprite_we_d;
            sprite_addr_q  <= sprite_addr_d;
            sprite_wdata_q <= sprite_wdata_d;
            push_q         <= push_d;
            push_req_q     <= push_req_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
        end
    end

    // FIFO storage write port.
    // NOTE: storage is not reset; emptiness lives in count_q and head outputs are masked while empty.
    always_ff @(posedge clock) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= push_req_q;
    end

    assign head           = fifo_mem[rd_ptr_q];
    assign draw_valid     = (count_q != '0);
    assign draw_sprite_id = draw_valid ? head.id   : '0;
    assign draw_x         = draw_valid ? head.x    : '0;
    assign draw_y         = draw_valid ? head.y    : '0;
    assign draw_attr      = draw_valid ? head.attr : '0;
    assign draw_overflow  = overflow_q;

    assign sprite_we      = sprite_we_q;
    assign sprite_addr    = sprite_addr_q;
    assign sprite_wdata   = sprite_wdata_q;

`ifdef SPI_EXEC_STATS_EN
    logic [15:0] saves_q, saves_d;
    logic [15:0] draws_q, draws_d;
    logic [15:0] drops_q, drops_d;
    logic        save_last;

    // The last pixel of a save is being issued this cycle.
    assign save_last = byte_v_q && (state_q == ST_SAVE_PIX) && (data_index == LAST_K);

    // Event counters; they wrap naturally at 16 bits.
    always_comb begin
        saves_d = saves_q + 16'(save_last);
        draws_d = draws_q + 16'(push_ok);
        drops_d = drops_q + 16'(push_drop);
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            saves_q <= '0;
            draws_q <= '0;
            drops_q <= '0;
        end else begin
            saves_q <= saves_d;
            draws_q <= draws_d;
            drops_q <= drops_d;
        end
    end

    assign stat_saves = saves_q;
    assign stat_draws = draws_q;
    assign stat_drops = drops_q;
`endif

endmodule

// File: tb/tb_spi_command_executor.sv
// Self-checking bench for spi_command_executor.
// A command-level model (op/id/args, expected FIFO queue) runs one step after every
// rising edge and is compared against the DUT outputs each cycle; directed sections
// add literal expectations for latency, ordering and overflow.
module tb_spi_command_executor;

    localparam int         SPRITE_BYTES = 512;
    localparam int         ID_W         = 8;
    localparam int         ADDR_W       = 17;
    localparam int         DEPTH        = 4;
    localparam logic [7:0] CMD_SAVE     = 8'h01;
    localparam logic [7:0] CMD_DRAW     = 8'h02;

    logic              clock = 1'b0;
    logic              reset;
    logic              byte_read;
    logic [7:0]        data;
    logic [7:0]        command;
    logic [15:0]       data_index;
    logic              sprite_we;
    logic [ADDR_W-1:0] sprite_addr;
    logic [7:0]        sprite_wdata;
    logic              draw_valid;
    logic              draw_ready;
    logic [ID_W-1:0]   draw_sprite_id;
    logic [15:0]       draw_x;
    logic [15:0]       draw_y;
    logic [7:0]        draw_attr;
    logic              draw_overflow;
`ifdef SPI_EXEC_STATS_EN
    logic [15:0]       stat_saves, stat_draws, stat_drops;
`endif

    spi_command_executor #(
        .SPRITE_BYTES        (SPRITE_BYTES),
        .SPRITE_ID_W         (ID_W),
        .DRAW_FIFO_DEPTH     (DEPTH),
        .COMMAND_SAVE_SPRITE (CMD_SAVE),
        .COMMAND_DRAW_SPRITE (CMD_DRAW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .byte_read      (byte_read),
        .data           (data),
        .command        (command),
        .data_index     (data_index),
        .sprite_we      (sprite_we),
        .sprite_addr    (sprite_addr),
        .sprite_wdata   (sprite_wdata),
        .draw_valid     (draw_valid),
        .draw_ready     (draw_ready),
        .draw_sprite_id (draw_sprite_id),
        .draw_x         (draw_x),
        .draw_y         (draw_y),
        .draw_attr      (draw_attr),
        .draw_overflow  (draw_overflow)
`ifdef SPI_EXEC_STATS_EN
        ,
        .stat_saves     (stat_saves),
        .stat_draws     (stat_draws),
        .stat_drops     (stat_drops)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Command-level reference model
    // ------------------------------------------------------------------
    typedef struct {
        int         due;
        logic [7:0] id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0] attr;
    } req_t;

    int          cyc = 0;
    int          op = 0;            // 0 none, 1 save, 2 draw
    bit          have_id = 0;
    logic [7:0]  sid;
    logic [7:0]  args [6];
    req_t        pend[$];
    req_t        fifo_m[$];
    bit          ovf_m = 0;
    bit          exp_we;
    int          exp_addr;
    logic [7:0]  exp_wdata;
    bit          prev_br = 0;
    logic [7:0]  prev_data;
    bit          pop_now;
    int          wr_seen = 0;
    int          m_saves = 0, m_draws = 0, m_drops = 0;

    task automatic model_byte(input logic [7:0] d, input logic [7:0] cmd, input int idx);
        req_t r;
        if (idx == 0) begin
            op      = (cmd == CMD_SAVE) ? 1 : (cmd == CMD_DRAW) ? 2 : 0;
            have_id = 0;
        end else if (op == 1) begin
            if (idx == 1) begin
                sid     = d;
                have_id = 1;
            end else if (have_id && idx >= 2 && idx <= SPRITE_BYTES + 1) begin
                exp_we    = 1;
                exp_addr  = int'(sid) * SPRITE_BYTES + (idx - 2);
                exp_wdata = d;
                if (idx == SPRITE_BYTES + 1) begin
                    op = 0;
                    m_saves++;
                end
            end
        end else if (op == 2 && idx >= 1 && idx <= 6) begin
            args[idx-1] = d;
            if (idx == 6) begin
                r.due  = cyc + 1;
                r.id   = args[0];
                r.x    = {args[1], args[2]};
                r.y    = {args[3], args[4]};
                r.attr = args[5];
                pend.push_back(r);
                op = 0;
            end
        end
    endtask

    // Model step and comparison, just after each rising edge.
    initial begin : compare
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            exp_we = 0;
            if (reset) begin
                fifo_m.delete();
                pend.delete();
                ovf_m   = 0;
                op      = 0;
                have_id = 0;
                prev_br = 0;
                m_saves = 0;
                m_draws = 0;
                m_drops = 0;
                check("rst_we",    32'(sprite_we),      0);
                check("rst_addr",  32'(sprite_addr),    0);
                check("rst_wdata", 32'(sprite_wdata),   0);
                check("rst_valid", 32'(draw_valid),     0);
                check("rst_id",    32'(draw_sprite_id), 0);
                check("rst_x",     32'(draw_x),         0);
                check("rst_y",     32'(draw_y),         0);
                check("rst_attr",  32'(draw_attr),      0);
                check("rst_ovf",   32'(draw_overflow),  0);
`ifdef SPI_EXEC_STATS_EN
                check("rst_stat_saves", 32'(stat_saves), 0);
                check("rst_stat_draws", 32'(stat_draws), 0);
                check("rst_stat_drops", 32'(stat_drops), 0);
`endif
            end else begin
                pop_now = (fifo_m.size() != 0) && draw_ready;
                if (pop_now) void'(fifo_m.pop_front());
                if (pend.size() != 0 && pend[0].due == cyc) begin
                    if (fifo_m.size() < DEPTH) begin
                        fifo_m.push_back(pend[0]);
                        m_draws++;
                    end else begin
                        ovf_m = 1;
                        m_drops++;
                    end
                    void'(pend.pop_front());
                end
                if (prev_br) model_byte(prev_data, command, int'(data_index));
                prev_br   = byte_read;
                prev_data = data;

                check("sprite_we", 32'(sprite_we), 32'(exp_we));
                if (exp_we) begin
                    check("sprite_addr",  32'(sprite_addr),  32'(exp_addr));
                    check("sprite_wdata", 32'(sprite_wdata), 32'(exp_wdata));
                end
                if (sprite_we) wr_seen++;
                check("draw_valid", 32'(draw_valid), 32'(fifo_m.size() != 0));
                if (fifo_m.size() != 0) begin
                    check("draw_id",   32'(draw_sprite_id), 32'(fifo_m[0].id));
                    check("draw_x",    32'(draw_x),         32'(fifo_m[0].x));
                    check("draw_y",    32'(draw_y),         32'(fifo_m[0].y));
                    check("draw_attr", 32'(draw_attr),      32'(fifo_m[0].attr));
                end
                check("draw_overflow", 32'(draw_overflow), 32'(ovf_m));
`ifdef SPI_EXEC_STATS_EN
                check("stat_saves", 32'(stat_saves), 32'(m_saves & 16'hFFFF));
                check("stat_draws", 32'(stat_draws), 32'(m_draws & 16'hFFFF));
                check("stat_drops", 32'(stat_drops), 32'(m_drops & 16'hFFFF));
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: emulates spi_reader (command/data_index update one cycle after byte_read)
    // ------------------------------------------------------------------
    int gap_max    = 2;
    bit rand_ready = 0;

    always @(negedge clock) begin
        if (rand_ready) draw_ready = ($urandom_range(0, 1) == 1);
    end

    task automatic send_byte(input logic [7:0] b, input bit is_cmd);
        @(negedge clock);
        byte_read = 1'b1;
        data      = b;
        @(negedge clock);
        byte_read = 1'b0;
        if (is_cmd) begin
            command    = b;
            data_index = 16'd0;
        end else begin
            data_index = data_index + 16'd1;
        end
        repeat ($urandom_range(0, gap_max)) @(negedge clock);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic send_data(input logic [7:0] b);
        send_byte(b, 1'b0);
    endtask

    task automatic send_draw(input logic [7:0] id, input logic [15:0] x,
                             input logic [15:0] y, input logic [7:0] attr);
        send_cmd(CMD_DRAW);
        send_data(id);
        send_data(x[15:8]);
        send_data(x[7:0]);
        send_data(y[15:8]);
        send_data(y[7:0]);
        send_data(attr);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset      = 1'b1;
        byte_read  = 1'b0;
        command    = 8'h00;
        data_index = 16'd0;
        @(negedge clock);
        reset = 1'b0;
        check("lit_rst_we",    32'(sprite_we),      0);
        check("lit_rst_addr",  32'(sprite_addr),    0);
        check("lit_rst_valid", 32'(draw_valid),     0);
        check("lit_rst_id",    32'(draw_sprite_id), 0);
        check("lit_rst_ovf",   32'(draw_overflow),  0);
    endtask

    task automatic drain();
        draw_ready = 1'b1;
        repeat (DEPTH + 2) @(negedge clock);
        draw_ready = 1'b0;
    endtask

    int base;

    initial begin : stimulus
        reset      = 1'b1;
        byte_read  = 1'b0;
        data       = 8'h00;
        command    = 8'h00;
        data_index = 16'd0;
        draw_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        do_reset();

        // Save sprite 0x05 with pixel p = p[7:0]; first pixel latency pinned literally.
        base = wr_seen;
        send_cmd(CMD_SAVE);
        send_data(8'h05);
        gap_max = 0;
        send_data(8'h00);
        check("lit_pix0_early", 32'(sprite_we), 0);
        @(negedge clock);
        check("lit_pix0_we",   32'(sprite_we),   1);
        check("lit_pix0_addr", 32'(sprite_addr), 32'h00A00);
        gap_max = 2;
        for (int p = 1; p < SPRITE_BYTES; p++) send_data(8'(p));
        for (int i = 0; i < 3; i++) send_data(8'hA5);
        repeat (4) @(negedge clock);
        check("lit_save_count", 32'(wr_seen - base), 512);

        // Draw 07 012C 00C8 03: valid appears three cycles after the last byte_read.
        send_cmd(CMD_DRAW);
        send_data(8'h07);
        send_data(8'h01);
        send_data(8'h2C);
        send_data(8'h00);
        send_data(8'hC8);
        gap_max = 0;
        send_data(8'h03);
        check("lit_draw_n1", 32'(draw_valid), 0);
        @(negedge clock);
        check("lit_draw_n2", 32'(draw_valid), 0);
        @(negedge clock);
        check("lit_draw_n3",   32'(draw_valid),     1);
        check("lit_draw_id",   32'(draw_sprite_id), 7);
        check("lit_draw_x",    32'(draw_x),         300);
        check("lit_draw_y",    32'(draw_y),         200);
        check("lit_draw_attr", 32'(draw_attr),      3);
        gap_max = 2;
        drain();

        // Unknown command produces nothing; the following draw works.
        base = wr_seen;
        send_cmd(8'hEE);
        for (int i = 0; i < 3; i++) send_data(8'(i + 2));
        send_draw(8'h09, 16'h1234, 16'h0056, 8'h77);
        repeat (4) @(negedge clock);
        check("lit_unknown_writes", 32'(wr_seen - base), 0);
        check("lit_unknown_draw",   32'(draw_sprite_id), 32'h09);
        drain();

        // Backpressure: five draws into a depth-4 FIFO, fifth dropped.
        do_reset();
        for (int i = 1; i <= 5; i++) send_draw(8'(i), 16'(i), 16'(i * 256), 8'(i));
        repeat (4) @(negedge clock);
        check("lit_bp_ovf", 32'(draw_overflow), 1);
        draw_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("lit_bp_order", 32'(draw_sprite_id), 32'(i));
            @(negedge clock);
        end
        check("lit_bp_empty", 32'(draw_valid), 0);
        draw_ready = 1'b0;

        // Full FIFO: last byte of a draw pushes in the same cycle as a pop.
        do_reset();
        for (int i = 0; i < 4; i++) send_draw(8'(8'h11 + i), 16'd5, 16'd6, 8'h00);
        repeat (4) @(negedge clock);
        check("lit_full_ovf0", 32'(draw_overflow), 0);
        send_cmd(CMD_DRAW);
        send_data(8'h15);
        send_data(8'h00);
        send_data(8'h05);
        send_data(8'h00);
        send_data(8'h05);
        gap_max = 0;
        send_data(8'h01);
        @(negedge clock);
        draw_ready = 1'b1;
        @(negedge clock);
        draw_ready = 1'b0;
        check("lit_full_head", 32'(draw_sprite_id), 32'h12);
        repeat (2) @(negedge clock);
        check("lit_full_ovf", 32'(draw_overflow), 0);
        draw_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("lit_full_order", 32'(draw_sprite_id), 32'(8'h12 + i));
            @(negedge clock);
        end
        draw_ready = 1'b0;
        gap_max = 2;

        // Reset after 100 pixels of a save; the next save restarts at pixel 0.
        send_cmd(CMD_SAVE);
        send_data(8'h05);
        for (int p = 0; p < 100; p++) send_data(8'(p));
        do_reset();
        base = wr_seen;
        send_cmd(CMD_SAVE);
        send_data(8'h09);
        gap_max = 0;
        send_data(8'h00);
        @(negedge clock);
        check("lit_restart_we",   32'(sprite_we),   1);
        check("lit_restart_addr", 32'(sprite_addr), 32'h01200);
        gap_max = 2;
        for (int p = 1; p < SPRITE_BYTES; p++) send_data(8'(p));
        repeat (4) @(negedge clock);
        check("lit_restart_count", 32'(wr_seen - base), 512);

        // Randomized mix of saves, draws, aborts and unknown commands with random ready.
        rand_ready = 1;
        for (int t = 0; t < 60; t++) begin
            int kind;
            int n;
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    send_cmd(CMD_SAVE);
                    send_data(8'($urandom));
                    n = $urandom_range(0, 20);
                    for (int i = 0; i < n; i++) send_data(8'($urandom));
                end
                1: begin
                    send_cmd(CMD_DRAW);
                    n = 6 + $urandom_range(0, 2);
                    for (int i = 0; i < n; i++) send_data(8'($urandom));
                end
                2: begin
                    send_cmd(CMD_DRAW);
                    n = $urandom_range(0, 5);
                    for (int i = 0; i < n; i++) send_data(8'($urandom));
                end
                default: begin
                    send_cmd(8'($urandom_range(3, 255)));
                    n = $urandom_range(0, 3);
                    for (int i = 0; i < n; i++) send_data(8'($urandom));
                end
            endcase
        end
        rand_ready = 0;
        @(negedge clock);
        draw_ready = 1'b1;
        repeat (10) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
